// File: rtl/riscv_pkg.sv
// Shared fetch/control definitions: fetch FSM states, base opcodes and the
// sequential PC increment.
package riscv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam int PC_STEP = 4;

endpackage

// File: rtl/pc_next_calc.sv
// Next-PC arithmetic: sequential pc+4 and word-aligned branch target
// cur_pc+offset. Purely combinational so a branch unit can reuse it.
module pc_next_calc
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic               [XLEN-1:0] pc_i,
  input  logic               [XLEN-1:0] cur_pc_i,
  input  logic signed        [XLEN-1:0] offset_i,
  output logic               [XLEN-1:0] seq_pc_o,
  output logic               [XLEN-1:0] branch_pc_o
);

  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(3);

  // Two's-complement offset: one unsigned adder covers forward and backward
  // branches, truncating modulo 2^XLEN.
  assign seq_pc_o    = pc_i + XLEN'(PC_STEP);
  assign branch_pc_o = (cur_pc_i + $unsigned(offset_i)) & ~ALIGN_MASK;

endmodule

// File: rtl/instr_fetch_unit.sv
// PC / instruction-register stage: one imem fetch per writepc rising edge,
// taken-branch PC updates, and a bounded wait for imem_ack.
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter int                XLEN     = 32,
  parameter logic [XLEN-1:0]   RESET_PC = '0,
  parameter int                TIMEOUT  = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   startpc,
  input  logic                   writepc,
  input  logic                   pc_load,
  input  logic signed [XLEN-1:0] branch_offset,
  output logic                   imem_req,
  output logic        [XLEN-1:0] imem_addr,
  input  logic                   imem_ack,
  input  logic        [31:0]     imem_rdata,
  output logic        [XLEN-1:0] pc,
  output logic        [XLEN-1:0] cur_pc,
  output logic        [31:0]     instr,
  output logic        [6:0]      opcode,
  output logic                   instr_valid,
  output logic                   fetch_busy,
  output logic                   fetch_fault
);

  localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  fetch_state_t      state_q;
  logic [XLEN-1:0]   pc_q;
  logic [XLEN-1:0]   cur_pc_q;
  logic [31:0]       instr_q;
  logic              instr_valid_q;
  logic              pending_q;
  logic              writepc_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              wp_rise_d;
  logic [XLEN-1:0]   seq_pc_d;
  logic [XLEN-1:0]   branch_pc_d;

  assign wp_rise_d = writepc & ~writepc_q;

  pc_next_calc #(
    .XLEN (XLEN)
  ) u_pc_next (
    .pc_i        (pc_q),
    .cur_pc_i    (cur_pc_q),
    .offset_i    (branch_offset),
    .seq_pc_o    (seq_pc_d),
    .branch_pc_o (branch_pc_d)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      cur_pc_q      <= RESET_PC;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      pending_q     <= 1'b0;
      writepc_q     <= 1'b0;
      cnt_q         <= '0;
    end else begin
      writepc_q <= writepc;
      if (!startpc) begin
        // Powered down: instr is deliberately kept for debug visibility.
        state_q       <= IDLE;
        pc_q          <= RESET_PC;
        cur_pc_q      <= RESET_PC;
        instr_valid_q <= 1'b0;
        pending_q     <= 1'b0;
        cnt_q         <= '0;
      end else begin
        if (wp_rise_d) pending_q <= 1'b1;
        case (state_q)
          IDLE: begin
            if (pc_load) begin
              pc_q <= branch_pc_d;
            end else if (pending_q) begin
              // A fresh rise in this same cycle stays queued.
              pending_q     <= wp_rise_d;
              state_q       <= REQ;
              cnt_q         <= '0;
              instr_valid_q <= 1'b0;
            end
          end
          REQ: begin
            if (imem_ack) begin
              instr_q       <= imem_rdata;
              cur_pc_q      <= pc_q;
              pc_q          <= seq_pc_d;
              instr_valid_q <= 1'b1;
              state_q       <= IDLE;
            end else if (cnt_q == CNT_LAST) begin
              state_q       <= FAULT;
              instr_valid_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          FAULT: begin
            instr_valid_q <= 1'b0;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Request/status decode straight from state so reset kills imem_req at once.
  assign imem_req    = (state_q == REQ);
  assign fetch_busy  = (state_q == REQ);
  assign fetch_fault = (state_q == FAULT);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign cur_pc      = cur_pc_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[6:0];
  assign instr_valid = instr_valid_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: fetch handshake, edge detect, branch,
// timeout fault, PC wrap and asynchronous reset.
module tb_instr_fetch_unit;

  logic        clk;
  logic        reset_n;
  logic        startpc;
  logic        writepc;
  logic        pc_load;
  logic [31:0] branch_offset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] cur_pc;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic        instr_valid;
  logic        fetch_busy;
  logic        fetch_fault;

  int checks = 0;
  int errors = 0;

  instr_fetch_unit #(
    .XLEN     (32),
    .RESET_PC (32'h0000_0000),
    .TIMEOUT  (16)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .startpc       (startpc),
    .writepc       (writepc),
    .pc_load       (pc_load),
    .branch_offset (branch_offset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .pc            (pc),
    .cur_pc        (cur_pc),
    .instr         (instr),
    .opcode        (opcode),
    .instr_valid   (instr_valid),
    .fetch_busy    (fetch_busy),
    .fetch_fault   (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The control unit never branches while a fetch is outstanding.
  always @(posedge clk) begin
    if (reset_n && imem_req && pc_load)
      $error("pc_load driven while imem_req is high");
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; startpc = 1'b0; writepc = 1'b0; pc_load = 1'b0;
    branch_offset = '0; imem_ack = 1'b0; imem_rdata = '0;
    tick(); tick();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem_req); end
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 00000000", pc); end
    checks++; if (cur_pc !== 32'h0) begin errors++; $display("FAIL reset_cur_pc: got %h want 00000000", cur_pc); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 00000000", instr); end
    checks++; if (instr_valid !== 1'b0 || fetch_fault !== 1'b0 || fetch_busy !== 1'b0) begin
      errors++; $display("FAIL reset_flags: got valid=%b fault=%b busy=%b want 0 0 0", instr_valid, fetch_fault, fetch_busy);
    end
    reset_n = 1'b1;
    tick();
    startpc = 1'b1;
    tick();
  endtask

  task automatic test_basic_fetch();
    writepc = 1'b1;
    tick();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL basic_latency1: imem_req got %b want 0", imem_req); end
    tick();
    checks++; if (imem_req !== 1'b1 || fetch_busy !== 1'b1) begin errors++; $display("FAIL basic_req: req=%b busy=%b want 1 1", imem_req, fetch_busy); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL basic_addr: got %h want 00000000", imem_addr); end
    tick();
    tick();
    imem_ack = 1'b1; imem_rdata = 32'h00A2_8233;
    tick();
    imem_ack = 1'b0; writepc = 1'b0;
    checks++; if (instr !== 32'h00A2_8233) begin errors++; $display("FAIL basic_instr: got %h want 00a28233", instr); end
    checks++; if (opcode !== 7'b0110011) begin errors++; $display("FAIL basic_opcode: got %b want 0110011", opcode); end
    checks++; if (cur_pc !== 32'h0 || pc !== 32'h4) begin errors++; $display("FAIL basic_pc: cur_pc=%h pc=%h want 00000000 00000004", cur_pc, pc); end
    checks++; if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("FAIL basic_valid: valid=%b req=%b want 1 0", instr_valid, imem_req); end
    tick();
  endtask

  task automatic test_held_writepc();
    int episodes;
    logic prev_req;
    logic [31:0] seen_addr;
    episodes = 0; prev_req = 1'b0; seen_addr = '1;
    writepc = 1'b1;
    for (int i = 0; i < 14; i++) begin
      if (i == 10) writepc = 1'b0;
      tick();
      if (imem_req && !prev_req) begin episodes++; seen_addr = imem_addr; end
      prev_req = imem_req;
      imem_ack = imem_req; imem_rdata = 32'h0040_0003;
    end
    imem_ack = 1'b0;
    checks++; if (episodes !== 1) begin errors++; $display("FAIL held_episodes: got %0d want 1", episodes); end
    checks++; if (seen_addr !== 32'h4) begin errors++; $display("FAIL held_addr: got %h want 00000004", seen_addr); end
    checks++; if (pc !== 32'h8 || cur_pc !== 32'h4) begin errors++; $display("FAIL held_pc: pc=%h cur_pc=%h want 00000008 00000004", pc, cur_pc); end

    episodes = 0; prev_req = 1'b0; seen_addr = '1;
    writepc = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (imem_req && !prev_req) begin episodes++; seen_addr = imem_addr; end
      prev_req = imem_req;
      imem_ack = imem_req; imem_rdata = 32'h0020_8023;
    end
    imem_ack = 1'b0; writepc = 1'b0;
    checks++; if (episodes !== 1 || seen_addr !== 32'h8) begin errors++; $display("FAIL toggle_fetch: episodes=%0d addr=%h want 1 00000008", episodes, seen_addr); end
    checks++; if (pc !== 32'hC || cur_pc !== 32'h8 || opcode !== 7'b0100011) begin
      errors++; $display("FAIL toggle_pc: pc=%h cur_pc=%h op=%b want 0000000c 00000008 0100011", pc, cur_pc, opcode);
    end
    tick();
  endtask

  task automatic test_branch();
    pc_load = 1'b1; branch_offset = 32'hFFFF_FFF8; writepc = 1'b1;
    tick();
    pc_load = 1'b0; branch_offset = '0;
    checks++; if (pc !== 32'h0 || imem_req !== 1'b0) begin errors++; $display("FAIL branch_pc: pc=%h req=%b want 00000000 0", pc, imem_req); end
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL branch_fetch: req=%b addr=%h want 1 00000000", imem_req, imem_addr); end
    imem_ack = 1'b1; imem_rdata = 32'h0000_0063;
    tick();
    imem_ack = 1'b0; writepc = 1'b0;
    checks++; if (cur_pc !== 32'h0 || pc !== 32'h4 || opcode !== 7'b1100011) begin
      errors++; $display("FAIL branch_done: cur_pc=%h pc=%h op=%b want 00000000 00000004 1100011", cur_pc, pc, opcode);
    end
    tick();
  endtask

  task automatic test_timeout();
    int n;
    writepc = 1'b1;
    tick();
    tick();
    n = imem_req ? 1 : 0;
    for (int i = 0; i < 40 && imem_req; i++) begin
      tick();
      if (imem_req) n++;
    end
    checks++; if (n !== 16) begin errors++; $display("FAIL timeout_cycles: got %0d REQ cycles want 16", n); end
    checks++; if (fetch_fault !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL timeout_fault: fault=%b req=%b valid=%b want 1 0 0", fetch_fault, imem_req, instr_valid);
    end
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    checks++; if (fetch_fault !== 1'b1 || instr !== 32'h0000_0063) begin errors++; $display("FAIL fault_sticky: fault=%b instr=%h want 1 00000063", fetch_fault, instr); end
    startpc = 1'b0; writepc = 1'b0;
    tick();
    startpc = 1'b1;
    checks++; if (fetch_fault !== 1'b0 || pc !== 32'h0 || cur_pc !== 32'h0) begin
      errors++; $display("FAIL startpc_clear: fault=%b pc=%h cur_pc=%h want 0 00000000 00000000", fetch_fault, pc, cur_pc);
    end
    checks++; if (instr !== 32'h0000_0063) begin errors++; $display("FAIL startpc_instr_kept: got %h want 00000063", instr); end
    tick();
  endtask

  task automatic test_wrap();
    pc_load = 1'b1; branch_offset = 32'hFFFF_FFFC;
    tick();
    pc_load = 1'b0; branch_offset = '0;
    checks++; if (pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_branch: pc=%h want fffffffc", pc); end
    writepc = 1'b1;
    tick();
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_req: req=%b addr=%h want 1 fffffffc", imem_req, imem_addr); end
    imem_ack = 1'b1; imem_rdata = 32'h0000_0013;
    tick();
    imem_ack = 1'b0; writepc = 1'b0;
    checks++; if (pc !== 32'h0 || cur_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc: pc=%h cur_pc=%h want 00000000 fffffffc", pc, cur_pc); end
    tick();
  endtask

  task automatic test_ack_at_limit();
    writepc = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 15; i++) tick();
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL limit_req: got %b want 1 on 16th REQ cycle", imem_req); end
    imem_ack = 1'b1; imem_rdata = 32'h0041_8183;
    tick();
    imem_ack = 1'b0; writepc = 1'b0;
    checks++; if (fetch_fault !== 1'b0 || instr_valid !== 1'b1 || instr !== 32'h0041_8183) begin
      errors++; $display("FAIL limit_ack: fault=%b valid=%b instr=%h want 0 1 00418183", fetch_fault, instr_valid, instr);
    end
    checks++; if (cur_pc !== 32'h0 || pc !== 32'h4) begin errors++; $display("FAIL limit_pc: cur_pc=%h pc=%h want 00000000 00000004", cur_pc, pc); end
    tick();
  endtask

  task automatic test_idle_ack_ignored();
    imem_ack = 1'b1; imem_rdata = 32'hCAFE_F00D;
    tick();
    tick();
    imem_ack = 1'b0;
    checks++; if (instr !== 32'h0041_8183 || pc !== 32'h4) begin errors++; $display("FAIL idle_ack: instr=%h pc=%h want 00418183 00000004", instr, pc); end
  endtask

  task automatic test_reset_mid_req();
    int seen;
    writepc = 1'b1;
    tick();
    tick();
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL midreq_enter: req=%b want 1", imem_req); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0 || fetch_busy !== 1'b0) begin errors++; $display("FAIL midreq_async: req=%b busy=%b want 0 0", imem_req, fetch_busy); end
    checks++; if (pc !== 32'h0 || cur_pc !== 32'h0 || instr !== 32'h0 || instr_valid !== 1'b0 || fetch_fault !== 1'b0) begin
      errors++; $display("FAIL midreq_state: pc=%h cur=%h instr=%h valid=%b fault=%b want all 0", pc, cur_pc, instr, instr_valid, fetch_fault);
    end
    writepc = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    tick();
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (imem_req) seen++;
    end
    imem_ack = 1'b0;
    checks++; if (seen !== 0 || instr !== 32'h0 || instr_valid !== 1'b0 || pc !== 32'h0) begin
      errors++; $display("FAIL midreq_ack_ignored: req_cycles=%0d instr=%h valid=%b pc=%h want 0 00000000 0 00000000", seen, instr, instr_valid, pc);
    end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_held_writepc();
    test_branch();
    test_timeout();
    test_wrap();
    test_ack_at_limit();
    test_idle_ack_ignored();
    test_reset_mid_req();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
